// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle divider: datapath widths, FSM state
// encoding, iteration count and an operand magnitude helper.
package div_pkg;

  localparam int unsigned REG_BUS        = 32;
  localparam int unsigned DOUBLE_REG_BUS = 64;

  // Final RUN iteration is the one seen with the counter at this value.
  localparam logic [5:0] LAST_ITER = 6'd31;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'd0,
    DIV_BY_ZERO = 2'd1,
    DIV_ON      = 2'd2,
    DIV_END     = 2'd3
  } div_state_e;

  // Magnitude of a two's complement operand; raw value for unsigned requests.
  function automatic logic [REG_BUS-1:0] abs32(input logic [REG_BUS-1:0] v,
                                               input logic is_signed);
    return (is_signed && v[REG_BUS-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/div.sv
// Multi-cycle 32-bit restoring divider for the EX stage DIV/DIVU instructions.
// One quotient bit per cycle; sign correction applied on the way out of RUN.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   start_i    division request, held by EX until ready_o
//   signed_i   1 = DIV (two's complement), 0 = DIVU
//   opdata1_i  dividend, sampled on acceptance only
//   opdata2_i  divisor, sampled on acceptance only
//   annul_i    cancel the in-flight division (pipeline flush)
//   busy_o     high while dividing (DIV_BY_ZERO / DIV_ON)
//   ready_o    registered, high while the result is presented
//   result_o   registered {remainder, quotient}, zero when not ready
module div
  import div_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic                      signed_i,
  input  logic [REG_BUS-1:0]        opdata1_i,
  input  logic [REG_BUS-1:0]        opdata2_i,
  input  logic                      annul_i,
  output logic                      busy_o,
  output logic                      ready_o,
  output logic [DOUBLE_REG_BUS-1:0] result_o
);

  div_state_e                state_q, state_d;
  logic [5:0]                cnt_q, cnt_d;
  logic [64:0]               w_q, w_d;
  logic [REG_BUS-1:0]        dvsr_q, dvsr_d;
  logic                      neg1_q, neg1_d;
  logic                      neg2_q, neg2_d;
  logic                      sgn_q, sgn_d;
  logic                      ready_q, ready_d;
  logic [DOUBLE_REG_BUS-1:0] result_q, result_d;

  logic                      accept;
  logic [65:0]               shifted;
  logic [33:0]               diff;

  assign accept = start_i && !annul_i;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DIV_FREE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides every state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DIV_FREE:    if (accept) state_d = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
      DIV_BY_ZERO: state_d = DIV_END;
      DIV_ON:      if (cnt_q == LAST_ITER) state_d = DIV_END;
      DIV_END:     if (!start_i) state_d = DIV_FREE;
      default:     state_d = DIV_FREE;
    endcase
    if (annul_i) state_d = DIV_FREE;
  end

  // Restoring step. W[64] is always 0 between steps (partial remainder is
  // below the divisor), so the 34-bit difference sign is a reliable borrow.
  assign shifted = {w_q, 1'b0};
  assign diff    = shifted[65:32] - {2'b00, dvsr_q};

  always_comb begin
    w_d    = w_q;
    cnt_d  = cnt_q;
    dvsr_d = dvsr_q;
    neg1_d = neg1_q;
    neg2_d = neg2_q;
    sgn_d  = sgn_q;
    if (state_q == DIV_FREE && accept) begin
      cnt_d  = '0;
      sgn_d  = signed_i;
      neg1_d = opdata1_i[REG_BUS-1];
      neg2_d = opdata2_i[REG_BUS-1];
      dvsr_d = abs32(opdata2_i, signed_i);
      // Divide-by-zero leaves W cleared so the corrected result is zero.
      w_d    = (opdata2_i == '0) ? '0 : {33'b0, abs32(opdata1_i, signed_i)};
    end else if (state_q == DIV_ON && !annul_i) begin
      cnt_d = cnt_q + 6'd1;
      if (diff[33]) w_d = shifted[64:0];
      else          w_d = {diff[32:0], shifted[31:1], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      w_q    <= '0;
      dvsr_q <= '0;
      neg1_q <= 1'b0;
      neg2_q <= 1'b0;
      sgn_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      w_q    <= w_d;
      dvsr_q <= dvsr_d;
      neg1_q <= neg1_d;
      neg2_q <= neg2_d;
      sgn_q  <= sgn_d;
    end
  end

  // Output logic. ready/result are registered one edge behind DIV_END and
  // fall on the same edge that leaves DIV_END.
  always_comb begin
    logic [REG_BUS-1:0] quot;
    logic [REG_BUS-1:0] rem;
    quot = w_q[31:0];
    rem  = w_q[63:32];
    if (sgn_q && (neg1_q ^ neg2_q)) quot = -quot;
    if (sgn_q && neg1_q)            rem  = -rem;
    busy_o   = (state_q == DIV_BY_ZERO) || (state_q == DIV_ON);
    ready_d  = (state_q == DIV_END) && start_i && !annul_i;
    result_d = ready_d ? {rem, quot} : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      ready_q  <= ready_d;
      result_q <= result_d;
    end
  end

  assign ready_o  = ready_q;
  assign result_o = result_q;

endmodule
